// File: rtl/beat_pkg.sv
// Shared definitions for the beat recorder / player pair.
// Holds the record payload layout written by the recorder and read by the
// player, plus the player state encoding and a small load helper.
package beat_pkg;

  localparam int unsigned KEY_W = 7;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned REC_W = KEY_W + CNT_W;

  // One run-length record: held key and its duration in ticks.
  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [CNT_W-1:0] count;
  } rec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2
  } player_state_e;

  // A zero-length record still plays for one tick.
  function automatic logic [CNT_W-1:0] load_count(input logic [CNT_W-1:0] c);
    return (c == '0) ? CNT_W'(1) : c;
  endfunction

endpackage

// File: rtl/rec_prefetch_buf.sv
// One-entry record prefetch buffer for the note player.
// Owns the RAM read port, the read address with wrap at rec_len-1, the
// outstanding-read tracking and the single buffered record.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   flush_i            drop buffer and any outstanding read (late data ignored)
//   start_i            issue the read of record 0 (playback start)
//   run_i              allow prefetching of the next record
//   pop_i              consumer takes the head record this cycle
//   rec_len_i          number of valid records
//   rdata_i            RAM data, valid one cycle after rd_en_o
//   rd_en_o, addr_o    registered RAM read strobe and address
//   head_rec_c_o       head record (buffered entry, else arriving data)
//   head_valid_c_o     head record is available this cycle
//   head_first_c_o     head record is record 0
module rec_prefetch_buf
  import beat_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              start_i,
  input  logic              run_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] rec_len_i,
  input  rec_t              rdata_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] addr_o,
  output rec_t              head_rec_c_o,
  output logic              head_valid_c_o,
  output logic              head_first_c_o
);

  rec_t              nxt_q, nxt_d;
  logic              nxt_valid_q, nxt_valid_d;
  logic              rd_en_q, rd_en_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] next_addr;

  assign last_addr = rec_len_i - ADDR_W'(1);
  assign next_addr = (rd_addr_q == last_addr) ? '0 : rd_addr_q + ADDR_W'(1);

  // Arriving data is bypassed to the head so a waiting consumer loads it at once.
  // Only one read is ever in flight, so rd_addr_q tags whichever record is at the head.
  assign head_valid_c_o = nxt_valid_q | rsp_valid_q;
  assign head_rec_c_o   = nxt_valid_q ? nxt_q : rdata_i;
  assign head_first_c_o = (rd_addr_q == '0);

  assign rd_en_o = rd_en_q;
  assign addr_o  = addr_q;

  // Buffer fill/drain and read issue.
  always_comb begin
    nxt_d       = nxt_q;
    nxt_valid_d = nxt_valid_q;
    rd_en_d     = 1'b0;
    rsp_valid_d = rd_en_q;
    rd_addr_d   = rd_addr_q;
    addr_d      = addr_q;
    if (flush_i) begin
      nxt_valid_d = 1'b0;
      rsp_valid_d = 1'b0;
    end else if (start_i) begin
      nxt_valid_d = 1'b0;
      rd_en_d     = 1'b1;
      rd_addr_d   = '0;
      addr_d      = '0;
    end else begin
      if (pop_i && head_valid_c_o) begin
        nxt_valid_d = 1'b0;
      end else if (rsp_valid_q) begin
        nxt_d       = rdata_i;
        nxt_valid_d = 1'b1;
      end
      if (run_i && !nxt_valid_q && !rd_en_q && !rsp_valid_q) begin
        rd_en_d   = 1'b1;
        rd_addr_d = next_addr;
        addr_d    = next_addr;
      end
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nxt_q       <= '0;
      nxt_valid_q <= 1'b0;
      rd_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rd_addr_q   <= '0;
      addr_q      <= '0;
    end else begin
      nxt_q       <= nxt_d;
      nxt_valid_q <= nxt_valid_d;
      rd_en_q     <= rd_en_d;
      rsp_valid_q <= rsp_valid_d;
      rd_addr_q   <= rd_addr_d;
      addr_q      <= addr_d;
    end
  end

endmodule

// File: rtl/rle_note_player.sv
// Run-length note playback engine.
// Reads {key, count} records from the recorder RAM and holds each key on
// the note output for count ticks, looping back to record 0 at the end.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   enable, rec_valid     play switch and recording-complete flag (levels)
//   tick                  time-base strobe
//   rec_len               number of valid records (0 = empty)
//   mem_rd_en, mem_addr   RAM read port (registered)
//   mem_rdata             RAM data {key, count}, valid one cycle after read
//   note, note_valid      current key code and play flag
//   loop_pulse            one cycle when record 0 is reloaded after a wrap
//   underrun              sticky: a boundary tick found no next record
module rle_note_player
  import beat_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   tick,
  input  logic                   rec_valid,
  input  logic [ADDR_W-1:0]      rec_len,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [KEY_W+CNT_W-1:0] mem_rdata,
  output logic [KEY_W-1:0]       note,
  output logic                   note_valid,
  output logic                   loop_pulse,
  output logic                   underrun
);

  player_state_e    state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             nv_q, nv_d;
  logic             lp_q, lp_d;
  logic             ur_q, ur_d;
  logic             pend_q, pend_d;

  logic flush_c, start_c, run_c, pop_c;
  rec_t head_rec;
  logic head_valid, head_first;

  assign flush_c = !enable || !rec_valid;

  rec_prefetch_buf #(
    .ADDR_W(ADDR_W)
  ) u_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_c),
    .start_i       (start_c),
    .run_i         (run_c),
    .pop_i         (pop_c),
    .rec_len_i     (rec_len),
    .rdata_i       (rec_t'(mem_rdata)),
    .rd_en_o       (mem_rd_en),
    .addr_o        (mem_addr),
    .head_rec_c_o  (head_rec),
    .head_valid_c_o(head_valid),
    .head_first_c_o(head_first)
  );

  // Next-state and output logic. pend_q marks a boundary that is still
  // waiting for its record; the current note is held meanwhile.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rem_d   = rem_q;
    lp_d    = 1'b0;
    ur_d    = ur_q;
    pend_d  = pend_q;
    start_c = 1'b0;
    pop_c   = 1'b0;
    run_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!flush_c && rec_len != '0) begin
          start_c = 1'b1;
          ur_d    = 1'b0;
          pend_d  = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (flush_c) begin
          state_d = ST_IDLE;
        end else if (head_valid) begin
          pop_c   = 1'b1;
          key_d   = head_rec.key;
          rem_d   = load_count(head_rec.count);
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        run_c = 1'b1;
        if (flush_c) begin
          pend_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (pend_q || (tick && rem_q == CNT_W'(1))) begin
          if (head_valid) begin
            pop_c  = 1'b1;
            key_d  = head_rec.key;
            rem_d  = load_count(head_rec.count);
            lp_d   = head_first;
            pend_d = 1'b0;
          end else begin
            ur_d   = 1'b1;
            pend_d = 1'b1;
          end
        end else if (tick) begin
          rem_d = rem_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    nv_d = (state_d == ST_PLAY);
  end

  // Player state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      rem_q   <= CNT_W'(1);
      nv_q    <= 1'b0;
      lp_q    <= 1'b0;
      ur_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rem_q   <= rem_d;
      nv_q    <= nv_d;
      lp_q    <= lp_d;
      ur_q    <= ur_d;
      pend_q  <= pend_d;
    end
  end

  assign note       = key_q;
  assign note_valid = nv_q;
  assign loop_pulse = lp_q;
  assign underrun   = ur_q;

endmodule

// File: tb/tb_rle_note_player.sv
// Directed self-checking bench for rle_note_player with a 1-cycle RAM model.
module tb_rle_note_player;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        tick = 1'b0;
  logic        rec_valid = 1'b0;
  logic [7:0]  rec_len = 8'd0;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [38:0] mem_rdata = '0;
  logic [6:0]  note;
  logic        note_valid;
  logic        loop_pulse;
  logic        underrun;

  logic [38:0] mem [0:255];

  int checks = 0;
  int errors = 0;
  int notes[$];
  int loops[$];
  int changes[$];
  int exp_q[$];
  int tick_cnt = 0;
  logic [6:0] last_note = '0;

  always #5 clk = ~clk;

  rle_note_player #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .tick      (tick),
    .rec_valid (rec_valid),
    .rec_len   (rec_len),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .note      (note),
    .note_valid(note_valid),
    .loop_pulse(loop_pulse),
    .underrun  (underrun)
  );

  // Record RAM: data valid the cycle after the read strobe.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_q(input string tag, input int got[$], input int exp[$]);
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 64'(i < got.size() ? got[i] : -1), 64'(exp[i]));
  endtask

  task automatic clear_log();
    notes.delete();
    loops.delete();
    changes.delete();
    tick_cnt  = 0;
    last_note = '0;
  endtask

  task automatic sample();
    if (tick && note_valid) begin
      tick_cnt++;
      notes.push_back(int'(note));
    end
    if (loop_pulse) loops.push_back(tick_cnt);
    if (note_valid && note !== last_note) begin
      changes.push_back(int'(note));
      last_note = note;
    end
  endtask

  // n ticks, one every per cycles, then two quiet cycles.
  task automatic play(input int n, input int per);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < per; c++) begin
        @(posedge clk); #1 tick = (c == per - 1);
        @(negedge clk); sample();
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1 tick = 1'b0;
      @(negedge clk); sample();
    end
  endtask

  // Enable and follow the fixed start-up latency; ends in cycle N+3.
  task automatic start_play(input string tag, input logic [6:0] k0);
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1;
    check({tag, "_rd0"}, 64'({mem_rd_en, mem_addr}), 64'({1'b1, 8'd0}));
    check({tag, "_ur_clr"}, 64'(underrun), 64'(0));
    @(posedge clk); #1;
    check({tag, "_nv_lat"}, 64'(note_valid), 64'(0));
    @(posedge clk); #1;
    check({tag, "_first"}, 64'({note_valid, note}), 64'({1'b1, k0}));
  endtask

  task automatic stop_play(input string tag);
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1;
    check({tag, "_stop"}, 64'(note_valid), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", 64'({note, note_valid, loop_pulse, underrun, mem_rd_en, mem_addr}), 64'(0));
    rst_n = 1'b1;
    rec_valid = 1'b1;

    // Three records, tick every 4 cycles.
    mem[0] = {7'h41, 32'd2};
    mem[1] = {7'h42, 32'd1};
    mem[2] = {7'h43, 32'd3};
    rec_len = 8'd3;
    clear_log();
    start_play("t1", 7'h41);
    @(posedge clk); #1;
    check("t1_prefetch", 64'({mem_rd_en, mem_addr}), 64'({1'b1, 8'd1}));
    play(9, 4);
    exp_q = '{65, 65, 66, 67, 67, 67, 65, 65, 66};
    check_q("t1_notes", notes, exp_q);
    check("t1_nloops", 64'(loops.size()), 64'(1));
    exp_q = '{6};
    check_q("t1_loop_at", loops, exp_q);
    check("t1_underrun", 64'(underrun), 64'(0));
    stop_play("t1");

    // Single record: every boundary reloads record 0.
    mem[0] = {7'h61, 32'd2};
    rec_len = 8'd1;
    clear_log();
    start_play("t2", 7'h61);
    play(6, 4);
    exp_q = '{97, 97, 97, 97, 97, 97};
    check_q("t2_notes", notes, exp_q);
    exp_q = '{2, 4, 6};
    check_q("t2_loops", loops, exp_q);
    check("t2_nloops", 64'(loops.size()), 64'(3));
    stop_play("t2");

    // Zero count plays for one tick.
    mem[0] = {7'h70, 32'd0};
    mem[1] = {7'h71, 32'd1};
    rec_len = 8'd2;
    clear_log();
    start_play("t0", 7'h70);
    play(4, 4);
    exp_q = '{112, 113, 112, 113};
    check_q("t0_notes", notes, exp_q);
    exp_q = '{2, 4};
    check_q("t0_loops", loops, exp_q);
    stop_play("t0");

    // Tick every cycle with unit counts: underrun, no skipped record.
    mem[0] = {7'h31, 32'd1};
    mem[1] = {7'h32, 32'd1};
    mem[2] = {7'h33, 32'd1};
    rec_len = 8'd3;
    clear_log();
    start_play("t3", 7'h31);
    play(20, 1);
    exp_q = '{49, 50, 51, 49, 50};
    check_q("t3_seq", changes, exp_q);
    check("t3_underrun", 64'(underrun), 64'(1));
    stop_play("t3");
    check("t3_ur_kept", 64'(underrun), 64'(1));
    start_play("t3r", 7'h31);

    // Reset mid-play.
    @(posedge clk); #1 rst_n = 1'b0; enable = 1'b0;
    #1;
    check("rst_mid", 64'({note, note_valid, loop_pulse, underrun, mem_rd_en, mem_addr}), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst_noread%0d", i), 64'(mem_rd_en), 64'(0));
    end

    // Enable dropped while the first read is in flight.
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1;
    check("late_rd", 64'(mem_rd_en), 64'(1));
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("late_note%0d", i), 64'({note_valid, note}), 64'(0));
    end

    // Empty recording or recording not valid: no reads.
    rec_len = 8'd0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("empty%0d", i), 64'({mem_rd_en, note_valid}), 64'(0));
    end
    rec_len = 8'd3;
    rec_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("novalid%0d", i), 64'({mem_rd_en, note_valid}), 64'(0));
    end
    enable = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
